// File: rtl/jk_counter_bank.sv
// jk_counter_bank
//   WIDTH-bit register built from JK cells, Qn = (J & ~Q) | (~K & Q).
//   Works as WIDTH independent JK flip-flops, or as a modulo/saturating
//   up/down counter with parallel load. Count and load modes never touch Q
//   directly: they only choose the J/K drive of every cell.
//
// Ports
//   CLK   in   1      clock, rising edge
//   RST   in   1      synchronous reset, active-high (Q <= RESET_VAL, WRAP <= 0)
//   EN    in   1      clock enable, 0 holds Q and WRAP
//   MODE  in   2      00 JK, 01 count up, 10 count down, 11 parallel load
//   J     in   WIDTH  per-bit J (MODE 00)
//   K     in   WIDTH  per-bit K (MODE 00)
//   D     in   WIDTH  load data (MODE 11)
//   Q     out  WIDTH  register state
//   TC    out  1      terminal count, combinational
//   WRAP  out  1      sticky wrap flag, cleared by reset or load
module jk_counter_bank #(
  parameter int WIDTH     = 4,
  parameter int MAX       = 2**WIDTH - 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP
);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_cell;
  logic [WIDTH-1:0] k_cell;
  logic [WIDTH-1:0] q_next;
  logic             at_max;
  logic             at_zero;
  logic             wrap_evt;

  assign at_max  = (Q >= MAX_V);
  assign at_zero = (Q == '0);

  // In count modes the desired next value is turned into a toggle mask
  // (bits that differ from Q); J=K=mask then toggles exactly those cells.
  always_comb begin
    target   = Q;
    wrap_evt = 1'b0;
    j_cell   = J;
    k_cell   = K;
    case (MODE)
      MODE_UP: begin
        if (!at_max) begin
          target = Q + ONE;
        end else if (SATURATE != 0) begin
          target = MAX_V;
        end else begin
          target   = '0;
          wrap_evt = 1'b1;
        end
        j_cell = Q ^ target;
        k_cell = Q ^ target;
      end
      MODE_DOWN: begin
        // Values above MAX (reachable via JK or load) snap back to MAX.
        if (Q > MAX_V) begin
          target = MAX_V;
        end else if (!at_zero) begin
          target = Q - ONE;
        end else if (SATURATE != 0) begin
          target = '0;
        end else begin
          target   = MAX_V;
          wrap_evt = 1'b1;
        end
        j_cell = Q ^ target;
        k_cell = Q ^ target;
      end
      MODE_LOAD: begin
        j_cell = D;
        k_cell = ~D;
      end
      default: begin
      end
    endcase
    q_next = (j_cell & ~Q) | (~k_cell & Q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= RST_V;
      WRAP <= 1'b0;
    end else if (EN) begin
      Q <= q_next;
      if (MODE == MODE_LOAD) begin
        WRAP <= 1'b0;
      end else if (wrap_evt) begin
        WRAP <= 1'b1;
      end
    end
  end

  assign TC = EN & ~RST & (((MODE == MODE_UP) & at_max) | ((MODE == MODE_DOWN) & at_zero));

endmodule

// File: tb/tb_jk_counter_bank.sv
// tb_jk_counter_bank
//   Drives a wrapping (SATURATE=0) and a saturating (SATURATE=1) instance,
//   WIDTH=4, MAX=9, from the same inputs and compares both against an
//   arithmetic reference model: directed sequences first, then random traffic.
module tb_jk_counter_bank;

  localparam int W  = 4;
  localparam int MX = 9;

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic [1:0]   MODE;
  logic [W-1:0] J, K, D;
  logic [W-1:0] q0, q1;
  logic         tc0, tc1, wrap0, wrap1;

  int n_cmp = 0;
  int n_err = 0;

  int m_q[2];
  int m_wrap[2];

  always #5 CLK = ~CLK;

  jk_counter_bank #(.WIDTH(W), .MAX(MX), .SATURATE(0), .RESET_VAL(0)) u_wrap (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .J(J), .K(K), .D(D),
    .Q(q0), .TC(tc0), .WRAP(wrap0)
  );

  jk_counter_bank #(.WIDTH(W), .MAX(MX), .SATURATE(1), .RESET_VAL(0)) u_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .J(J), .K(K), .D(D),
    .Q(q1), .TC(tc1), .WRAP(wrap1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_tc(input int q);
    if (RST || !EN) return 0;
    if (MODE == 2'b01 && q >= MX) return 1;
    if (MODE == 2'b10 && q == 0) return 1;
    return 0;
  endfunction

  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      if (RST) begin
        m_q[s] = 0;
        m_wrap[s] = 0;
      end else if (EN) begin
        case (MODE)
          2'b00: begin
            int nq;
            nq = 0;
            for (int b = 0; b < W; b++) begin
              int qb;
              qb = (m_q[s] >> b) & 1;
              case ({J[b], K[b]})
                2'b00: nq += qb << b;
                2'b10: nq += 1 << b;
                2'b01: nq += 0;
                default: nq += (1 - qb) << b;
              endcase
            end
            m_q[s] = nq;
          end
          2'b01: begin
            if (m_q[s] < MX) m_q[s] = m_q[s] + 1;
            else if (s == 1) m_q[s] = MX;
            else begin
              m_q[s] = 0;
              m_wrap[s] = 1;
            end
          end
          2'b10: begin
            if (m_q[s] > MX) m_q[s] = MX;
            else if (m_q[s] > 0) m_q[s] = m_q[s] - 1;
            else if (s == 0) begin
              m_q[s] = MX;
              m_wrap[s] = 1;
            end
          end
          default: begin
            m_q[s] = int'(D);
            m_wrap[s] = 0;
          end
        endcase
      end
    end
  endtask

  // Called just after a falling edge: apply inputs, check TC, clock, check state.
  task automatic cyc(input logic rst, input logic en, input logic [1:0] mode,
                     input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] d);
    RST = rst; EN = en; MODE = mode; J = j; K = k; D = d;
    #1;
    chk("tc_wrap", int'(tc0), model_tc(m_q[0]));
    chk("tc_sat",  int'(tc1), model_tc(m_q[1]));
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("q_wrap",    int'(q0),    m_q[0]);
    chk("q_sat",     int'(q1),    m_q[1]);
    chk("wrap_wrap", int'(wrap0), m_wrap[0]);
    chk("wrap_sat",  int'(wrap1), m_wrap[1]);
  endtask

  initial begin
    m_q[0] = 0; m_q[1] = 0; m_wrap[0] = 0; m_wrap[1] = 0;
    RST = 1'b1; EN = 1'b0; MODE = 2'b00; J = '0; K = '0; D = '0;
    @(negedge CLK);
    cyc(1, 0, 2'b00, 4'h0, 4'h0, 4'h0);
    chk("reset_q", int'(q0), 0);

    // Reach Q=7, WRAP=1, then reset.
    cyc(0, 1, 2'b11, 4'h0, 4'h0, 4'd9);
    cyc(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
    cyc(0, 1, 2'b00, 4'd7, 4'd8, 4'h0);
    chk("pre_rst_q", int'(q0), 7);
    chk("pre_rst_wrap", int'(wrap0), 1);
    cyc(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
    chk("rst_q", int'(q0), 0);
    chk("rst_wrap", int'(wrap0), 0);
    #1 chk("rst_tc", int'(tc0), 0);

    // JK mode sequence.
    cyc(0, 1, 2'b00, 4'b1010, 4'b0000, 4'h0);
    chk("jk_set", int'(q0), 4'b1010);
    cyc(0, 1, 2'b00, 4'b0000, 4'b1000, 4'h0);
    chk("jk_clr", int'(q0), 4'b0010);
    cyc(0, 1, 2'b00, 4'b1111, 4'b1111, 4'h0);
    chk("jk_tog", int'(q0), 4'b1101);
    cyc(0, 1, 2'b00, 4'b0000, 4'b0000, 4'h0);
    chk("jk_hold", int'(q0), 4'b1101);

    // Count up 12 edges from 0.
    cyc(1, 1, 2'b00, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
      chk("up_seq_q", int'(q0), (i + 1) % 10);
      chk("up_seq_wrap", int'(wrap0), (i >= 9) ? 1 : 0);
      chk("up_seq_tc_after", int'(tc0), ((i + 1) % 10 == 9) ? 1 : 0);
    end

    // Saturating count down from 1.
    cyc(0, 1, 2'b11, 4'h0, 4'h0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2'b10, 4'h0, 4'h0, 4'h0);
      chk("down_sat_q", int'(q1), 0);
      chk("down_sat_wrap", int'(wrap1), 0);
      chk("down_sat_tc", int'(tc1), 1);
    end

    // Load gated by EN, then wrap from above MAX.
    cyc(0, 1, 2'b11, 4'h0, 4'h0, 4'd5);
    cyc(0, 0, 2'b11, 4'h0, 4'h0, 4'b1100);
    chk("load_en0", int'(q0), 5);
    cyc(0, 1, 2'b11, 4'h0, 4'h0, 4'b1100);
    chk("load_en1", int'(q0), 12);
    cyc(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
    chk("up_over_q", int'(q0), 0);
    chk("up_over_wrap", int'(wrap0), 1);
    chk("up_over_sat_q", int'(q1), MX);

    // Reset on the same edge as a count.
    cyc(0, 1, 2'b11, 4'h0, 4'h0, 4'd6);
    cyc(1, 1, 2'b01, 4'h0, 4'h0, 4'h0);
    chk("rst_mid_q", int'(q0), 0);
    cyc(0, 1, 2'b01, 4'h0, 4'h0, 4'h0);
    chk("rst_after_q", int'(q0), 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
          2'($urandom_range(0, 3)),
          4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
